// File: rtl/eth_pkg.sv
// Shared definitions for the PRBS Ethernet test-frame generator.
// Provides the frame-builder state encoding and the fixed framing constants
// (preamble/SFD byte values and the preamble and MAC-header lengths).
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_IFG
    } state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         PREAMBLE_LEN  = 7;
    localparam int         HDR_LEN       = 14;

endpackage

// File: rtl/prbs_frame_gen_if.sv
// Byte-stream handshake between the frame generator and the TX path.
//   data  : current byte
//   valid : data is valid
//   last  : current byte is the final payload byte
//   ready : downstream accepts the current byte (transfer = valid && ready)
// master = frame generator, slave = TX path.
interface prbs_frame_gen_if;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    modport master (output data, output valid, output last, input  ready);
    modport slave  (input  data, input  valid, input  last, output ready);
endinterface

// File: rtl/prbs_frame_gen.sv
// Ethernet test-frame builder: preamble, SFD, MAC header, ethertype and a
// payload taken from the low byte of an external LFSR. Drives the LFSR seed
// load and step strobes so every frame restarts from the seed.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_start             : frame request, sampled only in IDLE
//   i_lfsr_data         : LFSR state, bits [7:0] form the payload byte
//   o_lfsr_rst_seed     : one-cycle seed-load pulse on the first PREAMBLE cycle
//   o_lfsr_enable       : steps the LFSR once per accepted payload byte
//   o_busy              : high in every state except IDLE
//   o_frame_cnt         : completed frames, wraps at 0xFFFF
//   tx (master)         : byte stream with valid/ready/last
module prbs_frame_gen
    import eth_pkg::*;
#(
    parameter int          LFSR_BITS   = 32,
    parameter int          PAYLOAD_LEN = 46,
    parameter int          IFG_CYCLES  = 12,
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [LFSR_BITS-1:0] i_lfsr_data,
    output logic                 o_lfsr_rst_seed,
    output logic                 o_lfsr_enable,
    output logic                 o_busy,
    output logic [15:0]          o_frame_cnt,
    prbs_frame_gen_if.master     tx
);

    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
    localparam logic [10:0] HDR_LAST = 11'(HDR_LEN - 1);
    localparam logic [10:0] PAY_LAST = 11'(PAYLOAD_LEN - 1);
    localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        seed_q, seed_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic        valid;
    logic        xfer;
    logic [7:0]  hdr_byte;
    logic [7:0]  data;

    // Only the low byte of the LFSR feeds the payload.
    wire unused_lfsr_hi = ^i_lfsr_data[LFSR_BITS-1:8];

    assign valid = (state_q == ST_PREAMBLE) || (state_q == ST_SFD) ||
                   (state_q == ST_HEADER)   || (state_q == ST_PAYLOAD);
    assign xfer  = valid && tx.ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seed_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: if (i_start) begin
                state_d = ST_PREAMBLE;
                cnt_d   = '0;
                seed_d  = 1'b1;   // seed pulse lands on the first PREAMBLE cycle only
            end
            ST_PREAMBLE: if (xfer) begin
                if (cnt_q == PRE_LAST) begin state_d = ST_SFD; cnt_d = '0; end
                else cnt_d = cnt_q + 11'd1;
            end
            ST_SFD: if (xfer) begin
                state_d = ST_HEADER;
                cnt_d   = '0;
            end
            ST_HEADER: if (xfer) begin
                if (cnt_q == HDR_LAST) begin state_d = ST_PAYLOAD; cnt_d = '0; end
                else cnt_d = cnt_q + 11'd1;
            end
            ST_PAYLOAD: if (xfer) begin
                if (cnt_q == PAY_LAST) begin state_d = ST_IFG; cnt_d = '0; end
                else cnt_d = cnt_q + 11'd1;
            end
            ST_IFG: begin
                // Gap timing is free-running; downstream backpressure is irrelevant here.
                if (cnt_q == IFG_LAST) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else cnt_d = cnt_q + 11'd1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            seed_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        hdr_byte = 8'h00;
        case (cnt_q)
            11'd0:  hdr_byte = DST_MAC[47:40];
            11'd1:  hdr_byte = DST_MAC[39:32];
            11'd2:  hdr_byte = DST_MAC[31:24];
            11'd3:  hdr_byte = DST_MAC[23:16];
            11'd4:  hdr_byte = DST_MAC[15:8];
            11'd5:  hdr_byte = DST_MAC[7:0];
            11'd6:  hdr_byte = SRC_MAC[47:40];
            11'd7:  hdr_byte = SRC_MAC[39:32];
            11'd8:  hdr_byte = SRC_MAC[31:24];
            11'd9:  hdr_byte = SRC_MAC[23:16];
            11'd10: hdr_byte = SRC_MAC[15:8];
            11'd11: hdr_byte = SRC_MAC[7:0];
            11'd12: hdr_byte = ETHERTYPE[15:8];
            11'd13: hdr_byte = ETHERTYPE[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        data = 8'h00;
        case (state_q)
            ST_PREAMBLE: data = PREAMBLE_BYTE;
            ST_SFD:      data = SFD_BYTE;
            ST_HEADER:   data = hdr_byte;
            ST_PAYLOAD:  data = i_lfsr_data[7:0];
            default:     data = 8'h00;
        endcase
    end

    assign tx.data         = data;
    assign tx.valid        = valid;
    assign tx.last         = (state_q == ST_PAYLOAD) && (cnt_q == PAY_LAST);
    assign o_busy          = (state_q != ST_IDLE);
    assign o_lfsr_rst_seed = seed_q;
    assign o_lfsr_enable   = (state_q == ST_PAYLOAD) && tx.ready;
    assign o_frame_cnt     = frame_cnt_q;

endmodule
